// File: rtl/alu.sv
// 32-bit MIPS-style integer ALU with next-HI/LO register for the EXE stage.
// Latency: aluResult is combinational (0 cycles); HI_OUT/LO_OUT register on rising CLK.
// Backpressure: none; multiply/divide complete in one cycle, no stall or busy signal.
module alu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_ADDU  = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SUBU  = 6'd3;
    localparam logic [5:0] OP_AND   = 6'd4;
    localparam logic [5:0] OP_OR    = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_NOR   = 6'd7;
    localparam logic [5:0] OP_SLT   = 6'd8;
    localparam logic [5:0] OP_SLTU  = 6'd9;
    localparam logic [5:0] OP_SLL   = 6'd10;
    localparam logic [5:0] OP_SRL   = 6'd11;
    localparam logic [5:0] OP_SRA   = 6'd12;
    localparam logic [5:0] OP_SLLV  = 6'd13;
    localparam logic [5:0] OP_SRLV  = 6'd14;
    localparam logic [5:0] OP_SRAV  = 6'd15;
    localparam logic [5:0] OP_LUI   = 6'd16;
    localparam logic [5:0] OP_MFHI  = 6'd17;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MTHI  = 6'd19;
    localparam logic [5:0] OP_MTLO  = 6'd20;
    localparam logic [5:0] OP_MULT  = 6'd21;
    localparam logic [5:0] OP_MULTU = 6'd22;
    localparam logic [5:0] OP_DIV   = 6'd23;
    localparam logic [5:0] OP_DIVU  = 6'd24;
    localparam logic [5:0] OP_PASSA = 6'd25;
    localparam logic [5:0] OP_PASSB = 6'd26;
    localparam logic [5:0] OP_CLZ   = 6'd27;
    localparam logic [5:0] OP_CLO   = 6'd28;

    logic [31:0] result;
    logic [5:0]  clz_cnt;
    logic [5:0]  clo_cnt;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] hi_out_d, hi_out_q;
    logic [31:0] lo_out_d, lo_out_q;

    // Leading zero / leading one counts: the highest set bit seen last wins.
    always_comb begin
        clz_cnt = 6'd32;
        clo_cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (A[i])  clz_cnt = 6'(31 - i);
            if (!A[i]) clo_cnt = 6'(31 - i);
        end
    end

    // Combinational result mux; reserved and HI/LO-writing codes yield zero.
    always_comb begin
        result = 32'h0;
        case (ALU_control)
            OP_ADD, OP_ADDU: result = A + B;
            OP_SUB, OP_SUBU: result = A - B;
            OP_AND:          result = A & B;
            OP_OR:           result = A | B;
            OP_XOR:          result = A ^ B;
            OP_NOR:          result = ~(A | B);
            OP_SLT:          result = {31'h0, $signed(A) < $signed(B)};
            OP_SLTU:         result = {31'h0, A < B};
            OP_SLL:          result = B << shiftAmount;
            OP_SRL:          result = B >> shiftAmount;
            OP_SRA:          result = $signed(B) >>> shiftAmount;
            OP_SLLV:         result = B << A[4:0];
            OP_SRLV:         result = B >> A[4:0];
            OP_SRAV:         result = $signed(B) >>> A[4:0];
            OP_LUI:          result = {B[15:0], 16'h0};
            OP_MFHI:         result = HI_IN;
            OP_MFLO:         result = LO_IN;
            OP_PASSA:        result = A;
            OP_PASSB:        result = B;
            OP_CLZ:          result = {26'h0, clz_cnt};
            OP_CLO:          result = {26'h0, clo_cnt};
            default:         result = 32'h0;
        endcase
    end

    assign aluResult = result;

    // Multiply and divide datapaths; divisor zero is guarded so no X reaches the mux.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'h0, A} * {32'h0, B};
        quot_s = 32'h0;
        rem_s  = 32'h0;
        quot_u = 32'h0;
        rem_u  = 32'h0;
        if (B != 32'h0) begin
            quot_u = A / B;
            rem_u  = A % B;
            // The one signed overflow case wraps to the dividend with zero remainder.
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'h0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
        end
    end

    // Next HI/LO selection; anything not writing HI/LO passes the current values through.
    always_comb begin
        hi_out_d = HI_IN;
        lo_out_d = LO_IN;
        case (ALU_control)
            OP_MTHI:  hi_out_d = A;
            OP_MTLO:  lo_out_d = A;
            OP_MULT:  {hi_out_d, lo_out_d} = prod_s;
            OP_MULTU: {hi_out_d, lo_out_d} = prod_u;
            OP_DIV: begin
                if (B != 32'h0) begin
                    hi_out_d = rem_s;
                    lo_out_d = quot_s;
                end
            end
            OP_DIVU: begin
                if (B != 32'h0) begin
                    hi_out_d = rem_u;
                    lo_out_d = quot_u;
                end
            end
            default: begin
                hi_out_d = HI_IN;
                lo_out_d = LO_IN;
            end
        endcase
    end

    // HI/LO register; reset clears immediately and drops any in-flight result.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_out_q <= 32'h0;
            lo_out_q <= 32'h0;
        end else begin
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
        end
    end

    assign HI_OUT = hi_out_q;
    assign LO_OUT = lo_out_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        CLK;
    logic        RESET;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic [31:0] HI_IN;
    logic [31:0] LO_IN;
    logic [31:0] aluResult;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;

    int compared   = 0;
    int mismatched = 0;

    alu dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .shiftAmount (shiftAmount),
        .HI_IN       (HI_IN),
        .LO_IN       (LO_IN),
        .aluResult   (aluResult),
        .HI_OUT      (HI_OUT),
        .LO_OUT      (LO_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply combinational inputs and let them settle.
    task automatic set_ops(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        ALU_control = op;
        A           = a;
        B           = b;
        shiftAmount = sh;
        #1;
    endtask

    // Advance to one rising edge, then sample one time unit later.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        A = 32'h0; B = 32'h0; ALU_control = 6'd0; shiftAmount = 5'd0;
        HI_IN = 32'h0; LO_IN = 32'h0;
        #3;
        check("reset_hi", HI_OUT, 32'h0);
        check("reset_lo", LO_OUT, 32'h0);

        // Release reset away from the rising edge.
        @(negedge CLK);
        RESET = 1'b1;

        set_ops(6'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        check("add_ovf", aluResult, 32'h8000_0000);
        set_ops(6'd3, 32'h0000_0005, 32'h0000_0007, 5'd0);
        check("subu_wrap", aluResult, 32'hFFFF_FFFE);

        HI_IN = 32'h11; LO_IN = 32'h22;
        set_ops(6'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        tick();
        check("pass_hi", HI_OUT, 32'h11);
        check("pass_lo", LO_OUT, 32'h22);

        // Logic and compare.
        set_ops(6'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        check("and", aluResult, 32'h00F0_00F0);
        set_ops(6'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        check("or", aluResult, 32'hFFF0_FFF0);
        set_ops(6'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        check("xor", aluResult, 32'hFF00_FF00);
        set_ops(6'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        check("nor", aluResult, 32'h000F_000F);
        set_ops(6'd8, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("slt", aluResult, 32'h1);
        set_ops(6'd9, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("sltu", aluResult, 32'h0);

        // Shifts.
        set_ops(6'd12, 32'h0, 32'h8000_0000, 5'd4);
        check("sra", aluResult, 32'hF800_0000);
        set_ops(6'd11, 32'h0, 32'h8000_0000, 5'd4);
        check("srl", aluResult, 32'h0800_0000);
        set_ops(6'd10, 32'h0, 32'h0000_0003, 5'd31);
        check("sll31", aluResult, 32'h8000_0000);
        set_ops(6'd13, 32'h23, 32'h1, 5'd0);
        check("sllv", aluResult, 32'h8);
        set_ops(6'd15, 32'h20, 32'h8000_0001, 5'd7);
        check("srav_zero", aluResult, 32'h8000_0001);
        set_ops(6'd14, 32'h4, 32'hF000_0000, 5'd0);
        check("srlv", aluResult, 32'h0F00_0000);
        set_ops(6'd16, 32'h0, 32'hABCD_1234, 5'd0);
        check("lui", aluResult, 32'h1234_0000);

        // Multiply.
        set_ops(6'd21, 32'hFFFF_FFFE, 32'h3, 5'd0);
        check("mult_res0", aluResult, 32'h0);
        tick();
        check("mult_hi", HI_OUT, 32'hFFFF_FFFF);
        check("mult_lo", LO_OUT, 32'hFFFF_FFFA);
        set_ops(6'd22, 32'hFFFF_FFFE, 32'h3, 5'd0);
        tick();
        check("multu_hi", HI_OUT, 32'h2);
        check("multu_lo", LO_OUT, 32'hFFFF_FFFA);

        // Divide.
        set_ops(6'd23, 32'hFFFF_FFF9, 32'h2, 5'd0);
        tick();
        check("div_lo", LO_OUT, 32'hFFFF_FFFD);
        check("div_hi", HI_OUT, 32'hFFFF_FFFF);
        set_ops(6'd24, 32'h7, 32'h2, 5'd0);
        tick();
        check("divu_lo", LO_OUT, 32'h3);
        check("divu_hi", HI_OUT, 32'h1);
        set_ops(6'd24, 32'hFFFF_FFF9, 32'h2, 5'd0);
        tick();
        check("divu_big_lo", LO_OUT, 32'h7FFF_FFFC);
        check("divu_big_hi", HI_OUT, 32'h1);
        set_ops(6'd23, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        tick();
        check("div_ovf_lo", LO_OUT, 32'h8000_0000);
        check("div_ovf_hi", HI_OUT, 32'h0);
        HI_IN = 32'hAA; LO_IN = 32'hBB;
        set_ops(6'd23, 32'h1234, 32'h0, 5'd0);
        tick();
        check("div0_hi", HI_OUT, 32'hAA);
        check("div0_lo", LO_OUT, 32'hBB);
        set_ops(6'd24, 32'h1234, 32'h0, 5'd0);
        tick();
        check("divu0_hi", HI_OUT, 32'hAA);
        check("divu0_lo", LO_OUT, 32'hBB);

        // Moves.
        LO_IN = 32'h55;
        set_ops(6'd19, 32'hDEAD_BEEF, 32'h0, 5'd0);
        tick();
        check("mthi_hi", HI_OUT, 32'hDEAD_BEEF);
        check("mthi_lo", LO_OUT, 32'h55);
        set_ops(6'd20, 32'hCAFE_F00D, 32'h0, 5'd0);
        tick();
        check("mtlo_lo", LO_OUT, 32'hCAFE_F00D);
        check("mtlo_hi", HI_OUT, 32'hAA);
        set_ops(6'd18, 32'h0, 32'h0, 5'd0);
        check("mflo", aluResult, 32'h55);
        set_ops(6'd17, 32'h0, 32'h0, 5'd0);
        check("mfhi", aluResult, 32'hAA);
        set_ops(6'd25, 32'h1357_9BDF, 32'h2468_ACE0, 5'd0);
        check("passa", aluResult, 32'h1357_9BDF);
        set_ops(6'd26, 32'h1357_9BDF, 32'h2468_ACE0, 5'd0);
        check("passb", aluResult, 32'h2468_ACE0);

        // Count leading zeros / ones.
        set_ops(6'd27, 32'h0001_0000, 32'h0, 5'd0);
        check("clz_15", aluResult, 32'd15);
        set_ops(6'd27, 32'h0, 32'h0, 5'd0);
        check("clz_32", aluResult, 32'd32);
        set_ops(6'd28, 32'hFFFF_FFFF, 32'h0, 5'd0);
        check("clo_32", aluResult, 32'd32);
        set_ops(6'd28, 32'hFF7F_FFFF, 32'h0, 5'd0);
        check("clo_8", aluResult, 32'd8);

        // Unlisted code gives zero.
        set_ops(6'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        check("unlisted", aluResult, 32'h0);

        // Reset asserted mid-cycle with a multiply pending clears at once.
        set_ops(6'd22, 32'h1000_0000, 32'h10, 5'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_hi", HI_OUT, 32'h0);
        check("midrst_lo", LO_OUT, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_hold_hi", HI_OUT, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        check("post_rst_hi", HI_OUT, 32'h1);
        check("post_rst_lo", LO_OUT, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit MIPS-style integer ALU inside the EXE stage.
- Combinational `aluResult` from operands A/B, a 6-bit operation code and a 5-bit shift amount.
- Also computes next HI/LO (multiply/divide/move-to) into registered outputs `HI_OUT`/`LO_OUT`. The EXE stage commits these to its architectural HI/LO and feeds them back on `HI_IN`/`LO_IN`.
- EXE drives `CLK` with its inverted clock, so the HI/LO register updates mid-cycle.

Parameters:
none

Ports:
CLK  input  1  clock; HI_OUT/LO_OUT update on rising edge
RESET  input  1  asynchronous active-low reset
A  input  32  operand A (rs)
B  input  32  operand B (rt / immediate)
ALU_control  input  6  operation select
shiftAmount  input  5  shamt for immediate shifts
HI_IN  input  32  current architectural HI
LO_IN  input  32  current architectural LO
aluResult  output  32  combinational result
HI_OUT  output  32  registered next-HI
LO_OUT  output  32  registered next-LO

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RESET).
- RESET low: HI_OUT=0, LO_OUT=0 immediately. aluResult is combinational and unaffected by reset.
- aluResult is a pure function of the current inputs, with zero latency. The ALU_control codes (decimal) are:
  - 0 ADD, 1 ADDU: A+B mod 2^32. No overflow trap.
  - 2 SUB, 3 SUBU: A-B mod 2^32.
  - 4 AND, 5 OR, 6 XOR, 7 NOR: bitwise.
  - 8 SLT: 1 if signed A<B, else 0. 9 SLTU: unsigned compare.
  - 10 SLL, 11 SRL, 12 SRA: B shifted by shiftAmount.
  - 13 SLLV, 14 SRLV, 15 SRAV: B shifted by A[4:0].
  - SRA/SRAV replicate B[31]; SRL/SRLV zero-fill. A shift of 0 returns B.
  - 16 LUI: {B[15:0],16'h0}.
  - 17 MFHI: HI_IN. 18 MFLO: LO_IN.
  - 25 PASSA: A. 26 PASSB: B.
  - 27 CLZ: count of leading zeros of A (0..32). 28 CLO: count of leading ones of A (0..32).
  - 19–24 and all unlisted codes (29–63): aluResult=0.
- HI/LO register, evaluated on each rising CLK when RESET high:
  - 19 MTHI: HI_OUT<=A, LO_OUT<=LO_IN.
  - 20 MTLO: LO_OUT<=A, HI_OUT<=HI_IN.
  - 21 MULT: {HI_OUT,LO_OUT}<=signed 64-bit A*B.
  - 22 MULTU: same, unsigned.
  - 23 DIV: LO_OUT<=signed quotient, truncated toward zero; HI_OUT<=remainder, sign follows dividend A.
  - 24 DIVU: unsigned quotient and remainder.
  - Divide with B=0 (either divide): HI_OUT<=HI_IN, LO_OUT<=LO_IN (no change, no error).
  - DIV 0x80000000/0xFFFFFFFF: LO_OUT=0x80000000, HI_OUT=0.
  - All other codes: HI_OUT<=HI_IN, LO_OUT<=LO_IN (pass-through, so the stage's latch is idempotent).
- Multiply/divide are single-cycle combinational into the register; no stall or busy handshake.
- Reset asserted mid-operation: registers clear at once; a pending multiply/divide result is discarded.
- Reset release: first rising CLK afterwards samples normally.

Test Plan:
- Reset/idle:
  - RESET=0 -> HI_OUT=LO_OUT=0 asynchronously.
  - Release; ALU_control=0, A=0x7FFFFFFF, B=1 -> aluResult=0x80000000 (no trap).
  - Clock with HI_IN=0x11, LO_IN=0x22 -> HI_OUT=0x11, LO_OUT=0x22.
- Logic/compare:
  - A=0xF0F0F0F0, B=0x0FF00FF0: AND=0x00F000F0, OR=0xFFF0FFF0, NOR=0x000F000F.
  - SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same -> 0.
- Shifts:
  - SRA B=0x80000000, shamt=4 -> 0xF8000000.
  - SRL same -> 0x08000000.
  - SLLV A=0x23 (uses 3), B=1 -> 8.
  - LUI B=0x1234 -> 0x12340000.
- Multiply:
  - MULT A=0xFFFFFFFE, B=3, clock -> HI_OUT=0xFFFFFFFF, LO_OUT=0xFFFFFFFA.
  - MULTU same -> HI_OUT=2, LO_OUT=0xFFFFFFFA.
- Divide:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> LO_OUT=0xFFFFFFFD, HI_OUT=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO_OUT=3, HI_OUT=1.
  - DIV by B=0 with HI_IN=0xAA, LO_IN=0xBB -> outputs 0xAA/0xBB.
- Moves/count:
  - MTHI A=0xDEADBEEF -> HI_OUT=0xDEADBEEF, LO_OUT=LO_IN.
  - MFLO with LO_IN=0x55 -> aluResult=0x55.
  - CLZ A=0x00010000 -> 15; CLZ A=0 -> 32.
  - CLO A=0xFFFFFFFF -> 32.
